// File: rtl/ram_addr_seq.sv
// Burst RAM address sequencer: loads start address and beat count, then issues one address per beat.
// Optional wrap-window increment enabled by defining RAM_ADDR_SEQ_WRAP_EN.
module ram_addr_seq #(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_LEN  = 4,
    parameter int WRAP_BITS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_start_addr,
    input  logic [SIZE_LEN-1:0]  i_burst_len,
    input  logic                 i_rd_en,
    input  logic                 i_wr_en,
    output logic [SIZE_ADDR-1:0] o_addr_ram,
    output logic                 o_busy,
    output logic                 o_last,
    output logic                 o_done,
    output logic                 o_err
);

    if (WRAP_BITS < 1 || WRAP_BITS > SIZE_ADDR) begin : g_bad_wrap_bits
        $error("ram_addr_seq: WRAP_BITS must be within 1..SIZE_ADDR");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_n;
    logic [SIZE_ADDR-1:0] addr_q, addr_n, addr_inc;
    logic [SIZE_LEN-1:0]  cnt_q, cnt_n;
    logic                 done_q, done_n, err_q, err_n;
    logic                 busy, beat, collide, cnt_zero;

    assign busy     = (state == BURST);
    assign cnt_zero = (cnt_q == '0);
    assign beat     = busy && (i_rd_en ^ i_wr_en);
    assign collide  = busy && i_rd_en && i_wr_en;

`ifdef RAM_ADDR_SEQ_WRAP_EN
    // Upper bits stay put; only the window offset rolls over.
    localparam logic [SIZE_ADDR-1:0] WMASK = {SIZE_ADDR{1'b1}} >> (SIZE_ADDR - WRAP_BITS);
    assign addr_inc = (addr_q & ~WMASK) | ((addr_q + 1'b1) & WMASK);
`else
    assign addr_inc = addr_q + 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_start) state_n = BURST;
            BURST:   if (beat && cnt_zero) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        addr_n = addr_q;
        cnt_n  = cnt_q;
        done_n = 1'b0;
        err_n  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    addr_n = i_start_addr;
                    cnt_n  = i_burst_len;
                end else if (i_rd_en || i_wr_en) begin
                    err_n = 1'b1;
                end
            end
            BURST: begin
                // A start during a burst is flagged but does not block the beat.
                err_n = i_start || collide;
                if (beat) begin
                    if (cnt_zero) begin
                        done_n = 1'b1;
                    end else begin
                        addr_n = addr_inc;
                        cnt_n  = cnt_q - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_n;
            cnt_q  <= cnt_n;
            done_q <= done_n;
            err_q  <= err_n;
        end
    end

    assign o_addr_ram = addr_q;
    assign o_busy     = busy;
    assign o_last     = busy && cnt_zero;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_ram_addr_seq.sv
// Directed vector bench for ram_addr_seq (default parameters, either build of RAM_ADDR_SEQ_WRAP_EN).
module tb_ram_addr_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, rd, wr;
    logic [7:0] sa;
    logic [3:0] len;
    logic [7:0] addr;
    logic       busy, last, done, err;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef RAM_ADDR_SEQ_WRAP_EN
    localparam logic [7:0] W0 = 8'hF0, W1 = 8'hF1;
`else
    localparam logic [7:0] W0 = 8'h00, W1 = 8'h01;
`endif

    ram_addr_seq dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_start_addr (sa),
        .i_burst_len  (len),
        .i_rd_en      (rd),
        .i_wr_en      (wr),
        .o_addr_ram   (addr),
        .o_busy       (busy),
        .o_last       (last),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [7:0] sa;
        logic [3:0] len;
        logic       rd, wr;
        logic [7:0] ea;
        logic       eb, el, ed, ee;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic s, logic [7:0] a, logic [3:0] l, logic r, logic w,
                                logic [7:0] ea, logic eb, logic el, logic ed, logic ee);
        vec_t v;
        v.start = s; v.sa = a; v.len = l; v.rd = r; v.wr = w;
        v.ea = ea; v.eb = eb; v.el = el; v.ed = ed; v.ee = ee;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] ea, input logic eb, el, ed, ee);
        chk({nm, " addr"}, 32'(addr), 32'(ea));
        chk({nm, " busy"}, 32'(busy), 32'(eb));
        chk({nm, " last"}, 32'(last), 32'(el));
        chk({nm, " done"}, 32'(done), 32'(ed));
        chk({nm, " err"},  32'(err),  32'(ee));
    endtask

    task automatic step(input logic s, input logic [7:0] a, input logic [3:0] l, input logic r, w);
        @(negedge clk);
        start = s; sa = a; len = l; rd = r; wr = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; sa = 0; len = 0; rd = 0; wr = 0;
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 8'h00, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        // basic burst 0x10 len 3
        add(1, 8'h10, 3, 0, 0, 8'h10, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 8'h11, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 8'h12, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 8'h13, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 8'h13, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 8'h13, 0, 0, 0, 0);
        // wrap 0xFE len 3 with writes
        add(1, 8'hFE, 3, 0, 0, 8'hFE, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 8'hFF, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, W0,    1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, W1,    1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, W1,    0, 0, 1, 0);
        // gaps and collision: 0x40 len 2 (started in the done cycle)
        add(1, 8'h40, 2, 0, 0, 8'h40, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 8'h41, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h41, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h41, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 1, 8'h41, 1, 0, 0, 1);
        add(0, 8'h00, 0, 1, 0, 8'h42, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 8'h42, 0, 0, 1, 0);
        // protocol errors
        add(0, 8'h00, 0, 0, 1, 8'h42, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 8'h42, 0, 0, 0, 0);
        add(1, 8'h80, 1, 0, 0, 8'h80, 1, 0, 0, 0);
        add(1, 8'h99, 5, 0, 0, 8'h80, 1, 0, 0, 1);
        add(0, 8'h00, 0, 1, 0, 8'h81, 1, 1, 0, 0);
        add(1, 8'h77, 2, 1, 0, 8'h81, 0, 0, 1, 1);
        add(1, 8'h33, 0, 0, 0, 8'h33, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 8'h33, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 8'h33, 0, 0, 0, 0);
        // start in IDLE with rd/wr: requests ignored, no error
        add(1, 8'h05, 0, 1, 1, 8'h05, 1, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h05, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 8'h05, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].sa, vecs[i].len, vecs[i].rd, vecs[i].wr);
            chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].el, vecs[i].ed, vecs[i].ee);
        end

        // reset mid-burst: 0x20 len 7, reset after beat 2, off the clock edge
        step(1, 8'h20, 7, 0, 0);
        chk_all("mid start", 8'h20, 1, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        step(0, 8'h00, 0, 1, 0);
        chk_all("mid beat2", 8'h22, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all("async rst", 8'h00, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1 chk("rst hold done", 32'(done), 32'd0);
        end
        @(negedge clk) begin rst_n = 1'b1; rd = 1'b0; end
        repeat (3) begin
            @(posedge clk);
            #1 chk_all("post rst", 8'h00, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_addr_seq.md
# ram_addr_seq

Parametrised burst address sequencer for the on-chip RAM path, successor to the single-shot RAM address register. It loads a start address and a beat count, then presents one RAM address per accepted read or write beat, auto-incrementing between beats. It reports burst progress (`o_busy`, `o_last`, `o_done`) and protocol errors (`o_err`). It sits between the access controller and the RAM address pin.

## Interface
- `SIZE_ADDR`, default 8: RAM address width.
- `SIZE_LEN`, default 4: burst length field width; a burst has `i_burst_len+1` beats, range 1..2^SIZE_LEN.
- `WRAP_BITS`, default 4: wrap window is 2^WRAP_BITS addresses. Used only with `RAM_ADDR_SEQ_WRAP_EN`. Constraint: 1 ≤ WRAP_BITS ≤ SIZE_ADDR.

Ports:
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  begin a burst; accepted only in IDLE.
- `i_start_addr`  in  SIZE_ADDR  first beat address; sampled with an accepted `i_start`.
- `i_burst_len`  in  SIZE_LEN  beats minus one; sampled with an accepted `i_start`.
- `i_rd_en`  in  1  read beat request.
- `i_wr_en`  in  1  write beat request.
- `o_addr_ram`  out  SIZE_ADDR  registered RAM address for the current beat.
- `o_busy`  out  1  registered; high in BURST.
- `o_last`  out  1  combinational: `o_busy` and remaining count == 0.
- `o_done`  out  1  registered; one-cycle pulse after the final beat is accepted.
- `o_err`  out  1  registered; one-cycle pulse on a protocol violation.

## Operation
- Two states, IDLE and BURST. Internal down-counter `cnt` is SIZE_LEN bits wide.
- A beat is accepted when `o_busy` is high and exactly one of `i_rd_en` or `i_wr_en` is high.
- **IDLE, `i_start` high:**
  - `o_addr_ram` <= `i_start_addr`, `cnt` <= `i_burst_len`, go to BURST.
  - `i_rd_en` and `i_wr_en` are ignored in that cycle.
- **IDLE, `i_rd_en` or `i_wr_en` high without `i_start`:** `o_err` pulses; address and state are unchanged.
- **BURST, accepted beat with `cnt` != 0:** `cnt` decrements and `o_addr_ram` advances by the increment rule below.
- **BURST, accepted beat with `cnt` == 0:**
  - Go to IDLE and pulse `o_done`.
  - `o_addr_ram` holds the final beat address and does not advance.
- **BURST, `i_rd_en` and `i_wr_en` both high:** `o_err` pulses; no advance; `cnt` is unchanged.
- **BURST, `i_start` high:** ignored; `o_err` pulses. This applies even in the final-beat cycle. Beat acceptance in that cycle still occurs normally.
- **BURST, no request:** all state holds; idle gaps between beats are legal.
- Increment rule without the macro: `o_addr_ram` + 1 modulo 2^SIZE_ADDR, so 0xFF goes to 0x00.
- When more than one error condition occurs in the same cycle, `o_err` is still a single pulse.

## Timing
- Reset values: `o_addr_ram` = 0, `o_busy` = 0, `o_done` = 0, `o_err` = 0, `cnt` = 0, state IDLE. Hence `o_last` = 0.
- Reset is asynchronous. Asserting it mid-burst returns the block to IDLE immediately; no `o_done` is produced.
- Start latency: `i_start` at cycle N makes `o_addr_ram` and `o_busy` valid at cycle N+1.
- The first beat may be requested at cycle N+1.
- The RAM uses the `o_addr_ram` value present in the cycle a beat is accepted. The next address appears on the following cycle, so full-rate bursts give one address per cycle.
- `o_done` is high in the cycle after the final accepted beat, and `o_busy` is low in that same cycle.
- A new `i_start` is accepted in the `o_done` cycle, giving back-to-back bursts with one dead cycle.
- `o_err` is high in the cycle after the offending request.

## Configuration
- `RAM_ADDR_SEQ_WRAP_EN` defined (wrap-window mode):
  - Bits [SIZE_ADDR-1:WRAP_BITS] of `o_addr_ram` are frozen for the whole burst.
  - Bits [WRAP_BITS-1:0] increment modulo 2^WRAP_BITS.
- `RAM_ADDR_SEQ_WRAP_EN` undefined: linear increment modulo 2^SIZE_ADDR. `WRAP_BITS` is unused.
- Ports and all other behaviour are identical in both builds.

## Test plan
All scenarios use default parameters.
- **Reset:** assert `i_rst_n` = 0 mid-simulation, asynchronous to the clock. Required: all outputs read 0 immediately, state IDLE.
- **Basic burst:** start 0x10, len 3, `i_rd_en` every cycle. Required:
  - `o_addr_ram` = 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
  - `o_last` high only with 0x13.
  - `o_done` pulses the next cycle while `o_addr_ram` holds 0x13.
- **Wrap:** start 0xFE, len 3, `i_wr_en` every cycle. Required:
  - Macro undefined: 0xFE, 0xFF, 0x00, 0x01.
  - Macro defined: 0xFE, 0xFF, 0xF0, 0xF1.
- **Gaps and collision:** start 0x40, len 2; beat; idle 2 cycles; `i_rd_en` and `i_wr_en` both high; beat; beat. Required:
  - Address sequence 0x40, 0x41 (held through the gap and the collision), 0x42.
  - `o_err` is exactly one pulse, `o_done` follows the third beat, and 3 beats are accepted in total.
- **Protocol errors:** `i_wr_en` in IDLE, then `i_start` during a burst, then `i_start` in the `o_done` cycle. Required:
  - Each of the first two produces one `o_err` pulse with the address unchanged.
  - The third is accepted: new start address at the next cycle, no `o_err`.
- **Reset mid-burst:** start 0x20, len 7, reset after beat 2. Required: `o_addr_ram` = 0, `o_busy` = 0, `o_done` never pulses.
